// File: rtl/mvm_ctrl.sv
// Sequencer for the serial matrix-vector multiply: loads A and X, sweeps the
// MAC over all products, writes row sums to Y, then streams Y back out.
module mvm_ctrl #(
  parameter int MAT_SCALE = 3,
  parameter int A_AW = ($clog2(MAT_SCALE*MAT_SCALE) > 1) ? $clog2(MAT_SCALE*MAT_SCALE) : 1,
  parameter int X_AW = ($clog2(MAT_SCALE) > 1) ? $clog2(MAT_SCALE) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic [A_AW-1:0] a_addr,
  output logic            a_wr_en,
  output logic [X_AW-1:0] x_addr,
  output logic            x_wr_en,
  output logic            mac_en,
  output logic            mac_clr,
  output logic [X_AW-1:0] y_wr_addr,
  output logic            y_wr_en,
  output logic [X_AW-1:0] y_rd_addr,
  output logic            done,
  output logic            out_valid
);

  // state   | meaning
  // IDLE    | waiting for start
  // LOAD_A  | streaming M*M matrix words into A
  // LOAD_X  | streaming M vector words into X
  // COMPUTE | issuing one product per cycle
  // FLUSH   | draining MAC and Y-write pipeline stages
  // DONE    | one-cycle done pulse, Y read of row 0 launched
  // OUT     | one result per cycle on data_out
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_A  = 3'd1;
  localparam logic [2:0] LOAD_X  = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] FLUSH   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] OUT     = 3'd6;

  localparam logic [A_AW-1:0] A_LAST     = A_AW'(MAT_SCALE*MAT_SCALE - 1);
  localparam logic [A_AW-1:0] M_LAST     = A_AW'(MAT_SCALE - 1);
  localparam logic [A_AW-1:0] FLUSH_LAST = A_AW'(1);
  localparam logic [X_AW-1:0] X_LAST     = X_AW'(MAT_SCALE - 1);

  logic [2:0]      state_q, state_d;
  logic [A_AW-1:0] cnt_q, cnt_d;
  logic [X_AW-1:0] col_q, col_d;
  logic [X_AW-1:0] row_q, row_d;
  logic            p1_en_q, p1_en_d;
  logic            p1_clr_q, p1_clr_d;
  logic            p1_last_q, p1_last_d;
  logic [X_AW-1:0] p1_row_q, p1_row_d;
  logic            y_en_q, y_en_d;
  logic [X_AW-1:0] y_row_q, y_row_d;
  logic            issue;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end
      end
      LOAD_A: begin
        if (cnt_q == A_LAST) begin
          state_d = LOAD_X;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD_X: begin
        if (cnt_q == M_LAST) begin
          state_d = COMPUTE;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        if (cnt_q == A_LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // column index wraps per row; row index saturates at M-1
          if (col_q == X_LAST) begin
            col_d = '0;
            row_d = (row_q == X_LAST) ? row_q : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = OUT;
        cnt_d   = '0;
      end
      OUT: begin
        if (cnt_q == M_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
      end
    endcase
  end

  // Issue -> MAC (+1) -> Y write (+2); stages run free so rows overlap.
  always_comb begin
    issue     = (state_q == COMPUTE);
    p1_en_d   = issue;
    p1_clr_d  = issue && (col_q == '0);
    p1_last_d = issue && (col_q == X_LAST);
    p1_row_d  = issue ? row_q : '0;
    y_en_d    = p1_en_q && p1_last_q;
    y_row_d   = (p1_en_q && p1_last_q) ? p1_row_q : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      p1_en_q   <= 1'b0;
      p1_clr_q  <= 1'b0;
      p1_last_q <= 1'b0;
      p1_row_q  <= '0;
      y_en_q    <= 1'b0;
      y_row_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      p1_en_q   <= p1_en_d;
      p1_clr_q  <= p1_clr_d;
      p1_last_q <= p1_last_d;
      p1_row_q  <= p1_row_d;
      y_en_q    <= y_en_d;
      y_row_q   <= y_row_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    a_wr_en   = (state_q == LOAD_A);
    a_addr    = (state_q == LOAD_A || state_q == COMPUTE) ? cnt_q : '0;
    x_wr_en   = (state_q == LOAD_X);
    x_addr    = (state_q == LOAD_X)  ? cnt_q[X_AW-1:0] :
                (state_q == COMPUTE) ? col_q : '0;
    mac_en    = p1_en_q;
    mac_clr   = p1_clr_q;
    y_wr_en   = y_en_q;
    y_wr_addr = y_row_q;
    done      = (state_q == DONE);
    out_valid = (state_q == OUT);
    // read address runs one ahead of the output because Y reads are registered
    if (state_q == OUT)
      y_rd_addr = (cnt_q == M_LAST) ? X_LAST : cnt_q[X_AW-1:0] + X_AW'(1);
    else
      y_rd_addr = '0;
  end

endmodule
